serial_pattern_detector: RTL

Serial bit-stream pattern detector that sits directly downstream of the bitwise XNOR equality stage. It shifts in one bit per enabled clock into a WIDTH-bit window. It compares the window against a fixed PATTERN with per-bit XNOR, then AND-reduces the result. It emits a one-cycle detect pulse and keeps a saturating count of detections. Overlapping matches are detected.

---
 rtl/spd_pkg.sv | 10 +
 rtl/window_compare.sv | 20 ++
 rtl/xnor_gate.sv | 8 +
 rtl/serial_pattern_detector.sv | 81 ++++++++
 4 files changed

// File: rtl/spd_pkg.sv
// Shared FSM encoding for the serial pattern detector.
package spd_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;
endpackage

// File: rtl/window_compare.sv
// Combinational WIDTH-bit compare of a window against a fixed pattern.
// Zero latency; no flow control.
module window_compare #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011
) (
    input  logic [WIDTH-1:0] win,
    output logic [WIDTH-1:0] eq_bits,
    output logic             all_eq
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xnor_gate u_xnor (
            .a (win[i]),
            .b (PATTERN[i]),
            .y (eq_bits[i])
        );
    end

    assign all_eq = &eq_bits;
endmodule

// File: rtl/xnor_gate.sv
// Single-bit equality cell; purely combinational.
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ~^ b;
endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector with overlap, fill tracking and a saturating hit count.
// Outputs register one clock after the enabled bit; en=0 stalls all state.
module serial_pattern_detector
    import spd_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic             detect,
    output logic [WIDTH-1:0] match_bits,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FILL_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  win;
    logic [WIDTH-1:0]  win_next;
    logic [WIDTH-1:0]  eq_bits;
    logic              all_eq;
    logic [FILL_W-1:0] fill_cnt;
    state_t            state;
    logic              completing;
    logic              qualified;
    logic              hit;

    assign win_next = en ? {win[WIDTH-2:0], din} : win;

    // The bit arriving now is the WIDTH-th since reset/clear.
    assign completing = (state != ARMED) && (fill_cnt == FILL_W'(WIDTH - 1));
    assign qualified  = en && ((state == ARMED) || completing);
    assign hit        = qualified && all_eq;

    window_compare #(
        .WIDTH   (WIDTH),
        .PATTERN (PATTERN)
    ) u_cmp (
        .win     (win_next),
        .eq_bits (eq_bits),
        .all_eq  (all_eq)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win        <= '0;
            fill_cnt   <= '0;
            state      <= EMPTY;
            detect     <= 1'b0;
            match_bits <= '0;
            match_cnt  <= '0;
            armed      <= 1'b0;
        end else begin
            detect <= hit;
            if (en) begin
                win        <= win_next;
                match_bits <= eq_bits;
                unique case (state)
                    EMPTY, FILL: begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (completing) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                    ARMED:   state <= ARMED;
                    default: state <= EMPTY;
                endcase
            end
            if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end
endmodule
